instr_encoder: RTL and testbench

//  Sequential RISC-V (RV32I subset) instruction encoder and program-memory writer.
//  - Accepts symbolic instructions (op enum + register fields + immediate) over a valid/ready handshake.
//  - Packs each into the 32-bit machine word that control_unit decodes.
//  - Writes words to consecutive instruction-memory addresses; used for boot/test program loading.

---
 rtl/instr_encoder.sv | 183 ++++++++++++++++++
 tb/tb_instr_encoder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: packs symbolic RV32I-subset instructions into 32-bit machine
// words and writes them to consecutive instruction-memory byte addresses.
// Ports:
//   clk, rst_n (sync, active-low), clear (sync restart)
//   in_valid/in_ready handshake with op, rd, rs1, rs2, imm
//   mem_we/mem_addr/mem_wdata memory write port
//   count (words written), full (count == DEPTH), err (1-cycle reject pulse)
module instr_encoder #(
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4:0]               op,
  input  logic [4:0]               rd,
  input  logic [4:0]               rs1,
  input  logic [4:0]               rs2,
  input  logic [31:0]              imm,
  output logic                     mem_we,
  output logic [31:0]              mem_addr,
  output logic [31:0]              mem_wdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     err
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_LD  = 7'b0000011;
  localparam logic [6:0] OPC_ST  = 7'b0100011;
  localparam logic [6:0] OPC_BR  = 7'b1100011;
  localparam logic [6:0] OPC_JAL = 7'b1101111;
  localparam logic [6:0] OPC_JR  = 7'b1100111;
  localparam logic [6:0] OPC_LUI = 7'b0110111;

  typedef enum logic [1:0] {S_IDLE, S_ENC, S_WRITE, S_FULL} state_t;

  state_t          r_state, w_state_nxt;
  logic [4:0]      r_op, r_rd, r_rs1, r_rs2;
  logic [31:0]     r_imm;
  logic            r_we, r_full, r_err;
  logic [31:0]     r_addr, r_wdata;
  logic [CW-1:0]   r_count;

  logic            w_we_nxt, w_full_nxt, w_err_nxt, w_cap;
  logic [31:0]     w_addr_nxt, w_wdata_nxt;
  logic [CW-1:0]   w_count_nxt;
  logic [31:0]     w_word;
  logic            w_ok;
  logic            w_i_ok, w_sh_ok, w_b_ok, w_j_ok, w_u_ok;

  // Immediate range checks on the captured two's-complement value
  assign w_i_ok  = (r_imm[31:11] == '0) || (r_imm[31:11] == '1);
  assign w_sh_ok = (r_imm[31:5] == '0);
  assign w_b_ok  = ((r_imm[31:12] == '0) || (r_imm[31:12] == '1)) && !r_imm[0];
  assign w_j_ok  = ((r_imm[31:20] == '0) || (r_imm[31:20] == '1)) && !r_imm[0];
  assign w_u_ok  = (r_imm[11:0] == '0);

  // Encoder: machine word and validity for the captured instruction
  always_comb begin
    w_word = '0;
    w_ok   = 1'b0;
    case (r_op)
      5'd0:  begin w_word = {7'b0000000, r_rs2, r_rs1, 3'b000, r_rd, OPC_R}; w_ok = 1'b1; end
      5'd1:  begin w_word = {7'b0100000, r_rs2, r_rs1, 3'b000, r_rd, OPC_R}; w_ok = 1'b1; end
      5'd2:  begin w_word = {7'b0000000, r_rs2, r_rs1, 3'b110, r_rd, OPC_R}; w_ok = 1'b1; end
      5'd3:  begin w_word = {7'b0000000, r_rs2, r_rs1, 3'b111, r_rd, OPC_R}; w_ok = 1'b1; end
      5'd4:  begin w_word = {7'b0000000, r_rs2, r_rs1, 3'b001, r_rd, OPC_R}; w_ok = 1'b1; end
      5'd5:  begin w_word = {7'b0000000, r_rs2, r_rs1, 3'b010, r_rd, OPC_R}; w_ok = 1'b1; end
      5'd6:  begin w_word = {7'b0000000, r_rs2, r_rs1, 3'b101, r_rd, OPC_R}; w_ok = 1'b1; end
      5'd7:  begin w_word = {r_imm[11:0], r_rs1, 3'b000, r_rd, OPC_I}; w_ok = w_i_ok; end
      5'd8:  begin w_word = {7'b0000000, r_imm[4:0], r_rs1, 3'b001, r_rd, OPC_I}; w_ok = w_sh_ok; end
      5'd9:  begin w_word = {r_imm[11:0], r_rs1, 3'b010, r_rd, OPC_I}; w_ok = w_i_ok; end
      5'd10: begin w_word = {7'b0000000, r_imm[4:0], r_rs1, 3'b101, r_rd, OPC_I}; w_ok = w_sh_ok; end
      5'd11: begin w_word = {r_imm[11:0], r_rs1, 3'b110, r_rd, OPC_I}; w_ok = w_i_ok; end
      5'd12: begin w_word = {r_imm[11:0], r_rs1, 3'b111, r_rd, OPC_I}; w_ok = w_i_ok; end
      5'd13: begin w_word = {r_imm[11:0], r_rs1, 3'b010, r_rd, OPC_LD}; w_ok = w_i_ok; end
      5'd14: begin w_word = {r_imm[11:5], r_rs2, r_rs1, 3'b010, r_imm[4:0], OPC_ST}; w_ok = w_i_ok; end
      5'd15: begin w_word = {r_imm[12], r_imm[10:5], r_rs2, r_rs1, 3'b000, r_imm[4:1], r_imm[11], OPC_BR}; w_ok = w_b_ok; end
      5'd16: begin w_word = {r_imm[12], r_imm[10:5], r_rs2, r_rs1, 3'b001, r_imm[4:1], r_imm[11], OPC_BR}; w_ok = w_b_ok; end
      5'd17: begin w_word = {r_imm[12], r_imm[10:5], r_rs2, r_rs1, 3'b100, r_imm[4:1], r_imm[11], OPC_BR}; w_ok = w_b_ok; end
      5'd18: begin w_word = {r_imm[12], r_imm[10:5], r_rs2, r_rs1, 3'b101, r_imm[4:1], r_imm[11], OPC_BR}; w_ok = w_b_ok; end
      5'd19: begin w_word = {r_imm[20], r_imm[10:1], r_imm[11], r_imm[19:12], r_rd, OPC_JAL}; w_ok = w_j_ok; end
      5'd20: begin w_word = {r_imm[11:0], r_rs1, 3'b000, r_rd, OPC_JR}; w_ok = w_i_ok; end
      5'd21: begin w_word = {r_imm[31:12], r_rd, OPC_LUI}; w_ok = w_u_ok; end
      default: begin w_word = '0; w_ok = 1'b0; end
    endcase
  end

  // Ready is combinational so a clear blocks the handshake in the same cycle
  assign in_ready = (r_state == S_IDLE) && !clear;
  assign w_cap    = in_valid && in_ready;

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt = r_state;
    w_we_nxt    = 1'b0;
    w_err_nxt   = 1'b0;
    w_full_nxt  = r_full;
    w_count_nxt = r_count;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    if (clear) begin
      w_state_nxt = S_IDLE;
      w_full_nxt  = 1'b0;
      w_count_nxt = '0;
      w_addr_nxt  = BASE_ADDR;
    end else begin
      case (r_state)
        S_IDLE: if (w_cap) w_state_nxt = S_ENC;
        S_ENC: begin
          if (w_ok) begin
            w_wdata_nxt = w_word;
            w_we_nxt    = 1'b1;
            w_state_nxt = S_WRITE;
          end else begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        S_WRITE: begin
          w_count_nxt = r_count + CW'(1);
          w_addr_nxt  = r_addr + 32'd4;
          if (r_count + CW'(1) == CW'(DEPTH)) begin
            w_full_nxt  = 1'b1;
            w_state_nxt = S_FULL;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_FULL:  w_state_nxt = S_FULL;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_full  <= 1'b0;
      r_count <= '0;
      r_addr  <= BASE_ADDR;
      r_wdata <= '0;
      r_op    <= '0;
      r_rd    <= '0;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_imm   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_we    <= w_we_nxt;
      r_err   <= w_err_nxt;
      r_full  <= w_full_nxt;
      r_count <= w_count_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
      if (w_cap) begin
        r_op  <= op;
        r_rd  <= rd;
        r_rs1 <= rs1;
        r_rs2 <= rs2;
        r_imm <= imm;
      end
    end
  end

  // A clear during the write cycle drops the word at the memory port
  assign mem_we    = r_we && !clear;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign count     = r_count;
  assign full      = r_full;
  assign err       = r_err;

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed-vector bench for instr_encoder (DEPTH=4, BASE_ADDR=0).
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n, clear, in_valid, in_ready;
  logic [4:0]  op, rd, rs1, rs2;
  logic [31:0] imm;
  logic        mem_we, full, err;
  logic [31:0] mem_addr, mem_wdata;
  logic [2:0]  count;

  int n_checks = 0;
  int n_errors = 0;

  instr_encoder #(.DEPTH(4), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .count(count), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one instruction from IDLE and capture the port values in each slot
  task automatic issue(input logic [4:0] i_op, input logic [4:0] i_rd, input logic [4:0] i_rs1,
                       input logic [4:0] i_rs2, input logic [31:0] i_imm,
                       output logic rdy0, output logic we1, output logic we2, output logic err2,
                       output logic [31:0] addr2, output logic [31:0] wdata2, output logic [2:0] cnt3);
    op = i_op; rd = i_rd; rs1 = i_rs1; rs2 = i_rs2; imm = i_imm;
    in_valid = 1'b1;
    rdy0 = in_ready;
    tick();
    in_valid = 1'b0;
    we1 = mem_we;
    tick();
    we2 = mem_we; err2 = err; addr2 = mem_addr; wdata2 = mem_wdata;
    tick();
    cnt3 = count;
  endtask

  task automatic clear_pulse();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0;
    op = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
    tick(); tick();
    n_checks++;
    if ({mem_we, mem_addr, mem_wdata, count, full, err} !== {1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL reset_vals we=%b addr=%h wdata=%h cnt=%0d full=%b err=%b", mem_we, mem_addr, mem_wdata, count, full, err);
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready got %b want 1", in_ready); end
  endtask

  task automatic test_add();
    logic r0, w1, w2, e2; logic [31:0] a2, d2; logic [2:0] c3;
    issue(5'd0, 5'd1, 5'd2, 5'd3, 32'd0, r0, w1, w2, e2, a2, d2, c3);
    n_checks++;
    if ({r0, w1, w2, e2} !== 4'b1010) begin n_errors++; $display("FAIL add_hs rdy=%b we_enc=%b we_wr=%b err=%b want 1,0,1,0", r0, w1, w2, e2); end
    n_checks++;
    if (a2 !== 32'h0 || d2 !== 32'h003100B3) begin n_errors++; $display("FAIL add_word addr=%h data=%h want 0 003100b3", a2, d2); end
    n_checks++;
    if (c3 !== 3'd1) begin n_errors++; $display("FAIL add_count got %0d want 1", c3); end
  endtask

  task automatic test_back_to_back();
    logic r0, w1, w2, e2; logic [31:0] a2, d2; logic [2:0] c3;
    clear_pulse();
    issue(5'd1, 5'd0, 5'd0, 5'd0, 32'd0, r0, w1, w2, e2, a2, d2, c3);
    n_checks++;
    if (w2 !== 1'b1 || a2 !== 32'h0 || d2 !== 32'h40000033) begin n_errors++; $display("FAIL sub_word we=%b addr=%h data=%h want 1 0 40000033", w2, a2, d2); end
    issue(5'd14, 5'd0, 5'd1, 5'd2, 32'd8, r0, w1, w2, e2, a2, d2, c3);
    n_checks++;
    if (w2 !== 1'b1 || a2 !== 32'h4 || d2 !== 32'h0020A423) begin n_errors++; $display("FAIL sw_word we=%b addr=%h data=%h want 1 4 0020a423", w2, a2, d2); end
    n_checks++;
    if (c3 !== 3'd2) begin n_errors++; $display("FAIL b2b_count got %0d want 2", c3); end
  endtask

  task automatic test_i_type();
    logic r0, w1, w2, e2; logic [31:0] a2, d2; logic [2:0] c3;
    logic [4:0]  t_op  [3] = '{5'd7, 5'd8, 5'd13};
    logic [4:0]  t_rd  [3] = '{5'd5, 5'd1, 5'd3};
    logic [4:0]  t_rs1 [3] = '{5'd0, 5'd2, 5'd2};
    logic [31:0] t_imm [3] = '{32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFC};
    logic [31:0] t_exp [3] = '{32'hFFF00293, 32'h00511093, 32'hFFC12183};
    clear_pulse();
    for (int i = 0; i < 3; i++) begin
      issue(t_op[i], t_rd[i], t_rs1[i], 5'd31, t_imm[i], r0, w1, w2, e2, a2, d2, c3);
      n_checks++;
      if (w2 !== 1'b1 || a2 !== 32'(4 * i) || d2 !== t_exp[i])
        begin n_errors++; $display("FAIL itype_%0d we=%b addr=%h data=%h want data %h", i, w2, a2, d2, t_exp[i]); end
    end
  endtask

  task automatic test_branch_jump_lui();
    logic r0, w1, w2, e2; logic [31:0] a2, d2; logic [2:0] c3;
    logic [4:0]  t_op  [3] = '{5'd15, 5'd19, 5'd21};
    logic [4:0]  t_rd  [3] = '{5'd0, 5'd1, 5'd5};
    logic [31:0] t_imm [3] = '{32'hFFFF_FFFC, 32'd8, 32'h12345000};
    logic [31:0] t_exp [3] = '{32'hFE000EE3, 32'h008000EF, 32'h123452B7};
    clear_pulse();
    for (int i = 0; i < 3; i++) begin
      issue(t_op[i], t_rd[i], 5'd0, 5'd0, t_imm[i], r0, w1, w2, e2, a2, d2, c3);
      n_checks++;
      if (w2 !== 1'b1 || a2 !== 32'(4 * i) || d2 !== t_exp[i])
        begin n_errors++; $display("FAIL bju_%0d we=%b addr=%h data=%h want data %h", i, w2, a2, d2, t_exp[i]); end
    end
    n_checks++;
    if (c3 !== 3'd3) begin n_errors++; $display("FAIL bju_count got %0d want 3", c3); end
  endtask

  // Runs after test_branch_jump_lui: count stays at 3 throughout
  task automatic test_reject();
    logic r0, w1, w2, e2; logic [31:0] a2, d2; logic [2:0] c3;
    logic [4:0]  t_op  [7] = '{5'd7, 5'd15, 5'd25, 5'd8, 5'd19, 5'd21, 5'd14};
    logic [31:0] t_imm [7] = '{32'd2048, 32'd3, 32'd0, 32'd32, 32'd3, 32'h12345001, 32'hFFFF_F7FF};
    for (int i = 0; i < 7; i++) begin
      issue(t_op[i], 5'd1, 5'd1, 5'd1, t_imm[i], r0, w1, w2, e2, a2, d2, c3);
      n_checks++;
      if ({r0, w1, w2, e2} !== 4'b1001 || c3 !== 3'd3)
        begin n_errors++; $display("FAIL reject_%0d rdy=%b we_enc=%b we_wr=%b err=%b cnt=%0d want 1,0,0,1,3", i, r0, w1, w2, e2, c3); end
    end
    n_checks++;
    if (err !== 1'b0) begin n_errors++; $display("FAIL err_pulse_width got %b want 0", err); end
  endtask

  task automatic test_full();
    logic r0, w1, w2, e2; logic [31:0] a2, d2; logic [2:0] c3;
    logic we_seen;
    clear_pulse();
    for (int i = 0; i < 4; i++) issue(5'd2, 5'd4, 5'd5, 5'd6, 32'd0, r0, w1, w2, e2, a2, d2, c3);
    n_checks++;
    if ({full, in_ready, count} !== {1'b1, 1'b0, 3'd4}) begin n_errors++; $display("FAIL full_state full=%b rdy=%b cnt=%0d want 1 0 4", full, in_ready, count); end
    we_seen = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin tick(); we_seen |= mem_we; end
    in_valid = 1'b0;
    n_checks++;
    if (we_seen !== 1'b0 || count !== 3'd4) begin n_errors++; $display("FAIL full_ignore we_seen=%b cnt=%0d want 0 4", we_seen, count); end
    clear = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin n_errors++; $display("FAIL clear_ready got %b want 0", in_ready); end
    tick();
    clear = 1'b0;
    #1;
    n_checks++;
    if ({count, mem_addr, full, in_ready} !== {3'd0, 32'h0, 1'b0, 1'b1}) begin n_errors++; $display("FAIL full_clear cnt=%0d addr=%h full=%b rdy=%b", count, mem_addr, full, in_ready); end
  endtask

  task automatic test_clear_and_reset();
    logic r0, w1, w2, e2; logic [31:0] a2, d2; logic [2:0] c3;
    op = 5'd0; rd = 5'd1; rs1 = 5'd2; rs2 = 5'd3; imm = '0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    clear = 1'b1;
    #1;
    n_checks++;
    if (mem_we !== 1'b0) begin n_errors++; $display("FAIL clear_write_we got %b want 0", mem_we); end
    tick();
    clear = 1'b0;
    n_checks++;
    if (count !== 3'd0 || mem_addr !== 32'h0) begin n_errors++; $display("FAIL clear_write_cnt cnt=%0d addr=%h want 0 0", count, mem_addr); end
    issue(5'd3, 5'd7, 5'd8, 5'd9, 32'd0, r0, w1, w2, e2, a2, d2, c3);
    n_checks++;
    if (c3 !== 3'd1 || mem_addr !== 32'h4) begin n_errors++; $display("FAIL pre_rst_word cnt=%0d addr=%h want 1 4", c3, mem_addr); end
    op = 5'd0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    n_checks++;
    if ({mem_we, mem_addr, mem_wdata, count, full, err} !== {1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL rst_mid_enc we=%b addr=%h wdata=%h cnt=%0d full=%b err=%b", mem_we, mem_addr, mem_wdata, count, full, err);
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (in_ready !== 1'b1 || mem_we !== 1'b0) begin n_errors++; $display("FAIL rst_release rdy=%b we=%b want 1 0", in_ready, mem_we); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_i_type();
    test_branch_jump_lui();
    test_reject();
    test_full();
    test_clear_and_reset();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
